// File: rtl/sc_screen_sequencer_pkg.sv
// Shared state encoding, transition-image selects and width helpers for the screen sequencer.
package sc_screen_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CRASH = 3'd2,
    ST_LEVEL = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_LEVEL = 2'd1;
  localparam logic [1:0] SEL_OVER  = 2'd2;
  localparam logic [1:0] SEL_WIN   = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_tick_timer.sv
// Prescaler plus saturating tick counter with synchronous clear and a done flag.
// SC_SCREEN_SEQUENCER_CRASH_BLINK_EN additionally exposes the per-tick strobe.
module sc_tick_timer
  import sc_screen_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALER = 25000000,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_target,
`ifdef SC_SCREEN_SEQUENCER_CRASH_BLINK_EN
  output logic             o_tick_c,
`endif
  output logic             o_done_c
);

  localparam int unsigned      PRE_W   = width_for(PRESCALER);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick   = (r_pre == PRE_MAX);
  // Done on the last cycle of the target-th tick, so the owner's next edge leaves.
  assign o_done_c = w_tick && (r_cnt == i_target - CNT_W'(1));

`ifdef SC_SCREEN_SEQUENCER_CRASH_BLINK_EN
  assign o_tick_c = w_tick;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sc_screen_sequencer.sv
// Game screen sequencer: START/PLAY/CRASH/LEVEL/OVER FSM with registered Moore outputs.
// SC_SCREEN_SEQUENCER_CRASH_BLINK_EN makes CRASH a BLINK_TICKS-long blinking screen.
module sc_screen_sequencer
  import sc_screen_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALER   = 25000000,
  parameter int unsigned HOLD_TICKS  = 4,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned LEVELS      = 4,
  parameter int unsigned BLINK_TICKS = 6
) (
  input  logic       SC_SCREEN_SEQUENCER_CLOCK_50,
  input  logic       SC_SCREEN_SEQUENCER_RESET_InLow,
  input  logic       SC_SCREEN_SEQUENCER_start_InLow,
  input  logic       SC_SCREEN_SEQUENCER_crash_InHigh,
  input  logic       SC_SCREEN_SEQUENCER_levelDone_InHigh,
  output logic       SC_SCREEN_SEQUENCER_muxScreen_Out,
  output logic [1:0] SC_SCREEN_SEQUENCER_transSel_Out,
  output logic       SC_SCREEN_SEQUENCER_gameEn_Out,
  output logic       SC_SCREEN_SEQUENCER_gameClear_Out,
  output logic [1:0] SC_SCREEN_SEQUENCER_level_Out,
  output logic [1:0] SC_SCREEN_SEQUENCER_lives_Out
);

  localparam int unsigned      CNT_W      = width_for(max_u(HOLD_TICKS, BLINK_TICKS) + 1);
  localparam logic [CNT_W-1:0] HOLD_TGT   = CNT_W'(HOLD_TICKS);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [1:0]       LEVEL_LAST = 2'(LEVELS - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic             w_start;
  logic             w_crash;
  logic             w_level_done;
  logic             w_state_change;
  logic             w_done;
  logic [CNT_W-1:0] w_target;

  logic       r_mux, w_mux;
  logic [1:0] r_sel, w_sel;
  logic       r_game_en, w_game_en;
  logic       r_game_clear, w_game_clear;
  logic [1:0] r_level, w_level;
  logic [1:0] r_lives, w_lives;

  assign w_start        = ~SC_SCREEN_SEQUENCER_start_InLow;
  assign w_crash        = SC_SCREEN_SEQUENCER_crash_InHigh;
  assign w_level_done   = SC_SCREEN_SEQUENCER_levelDone_InHigh;
  assign w_state_change = (w_next_state != r_state);

`ifdef SC_SCREEN_SEQUENCER_CRASH_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_TGT = CNT_W'(BLINK_TICKS);
  logic w_tick;
  assign w_target = (r_state == ST_CRASH) ? BLINK_TGT : HOLD_TGT;
`else
  assign w_target = HOLD_TGT;
`endif

  sc_tick_timer #(
    .PRESCALER (PRESCALER),
    .CNT_W     (CNT_W)
  ) u_timer (
    .i_clk    (SC_SCREEN_SEQUENCER_CLOCK_50),
    .i_rst_n  (SC_SCREEN_SEQUENCER_RESET_InLow),
    .i_clear  (w_state_change),
    .i_target (w_target),
`ifdef SC_SCREEN_SEQUENCER_CRASH_BLINK_EN
    .o_tick_c (w_tick),
`endif
    .o_done_c (w_done)
  );

  always_ff @(posedge SC_SCREEN_SEQUENCER_CLOCK_50) begin
    if (!SC_SCREEN_SEQUENCER_RESET_InLow) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state; crash outranks levelDone in PLAY, every other input is ignored elsewhere.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_START: if (w_start) w_next_state = ST_PLAY;
      ST_PLAY: begin
        if (w_crash) begin
          w_next_state = (r_lives <= 2'd1) ? ST_OVER : ST_CRASH;
        end else if (w_level_done) begin
          w_next_state = (r_level >= LEVEL_LAST) ? ST_OVER : ST_LEVEL;
        end
      end
`ifdef SC_SCREEN_SEQUENCER_CRASH_BLINK_EN
      ST_CRASH: if (w_done) w_next_state = ST_PLAY;
`else
      ST_CRASH: w_next_state = ST_PLAY;
`endif
      ST_LEVEL: if (w_done) w_next_state = ST_PLAY;
      ST_OVER:  if (w_done) w_next_state = ST_START;
      default:  w_next_state = ST_START;
    endcase
  end

  // Next output values, keyed on the state being entered so they land with it.
  always_comb begin
    w_mux        = r_mux;
    w_sel        = r_sel;
    w_game_en    = r_game_en;
    w_game_clear = 1'b0;
    w_level      = r_level;
    w_lives      = r_lives;
    case (w_next_state)
      ST_START: begin
        w_mux     = 1'b1;
        w_sel     = SEL_START;
        w_game_en = 1'b0;
      end
      ST_PLAY: begin
        w_mux        = 1'b0;
        w_game_en    = 1'b1;
        w_game_clear = (r_state != ST_PLAY);
      end
      ST_LEVEL: begin
        w_mux     = 1'b1;
        w_sel     = SEL_LEVEL;
        w_game_en = 1'b0;
      end
      ST_OVER: begin
        w_mux     = 1'b1;
        w_game_en = 1'b0;
        if (r_state == ST_PLAY) w_sel = w_crash ? SEL_OVER : SEL_WIN;
      end
      ST_CRASH: begin
        w_game_en = 1'b0;
`ifdef SC_SCREEN_SEQUENCER_CRASH_BLINK_EN
        if (r_state != ST_CRASH) begin
          w_mux = 1'b1;
          w_sel = SEL_OVER;
        end else if (w_tick) begin
          w_mux = ~r_mux;
        end
`else
        w_mux = 1'b0;
`endif
      end
      default: ;
    endcase

    if ((r_state == ST_START) && (w_next_state == ST_PLAY)) begin
      w_level = 2'd0;
      w_lives = LIVES_INIT;
    end
    if ((r_state == ST_LEVEL) && (w_next_state == ST_PLAY) && (r_level != LEVEL_LAST)) begin
      w_level = r_level + 2'd1;
    end
    if ((r_state == ST_PLAY) && w_crash && (r_lives != 2'd0)) begin
      w_lives = r_lives - 2'd1;
    end
  end

  always_ff @(posedge SC_SCREEN_SEQUENCER_CLOCK_50) begin
    if (!SC_SCREEN_SEQUENCER_RESET_InLow) begin
      r_mux        <= 1'b1;
      r_sel        <= SEL_START;
      r_game_en    <= 1'b0;
      r_game_clear <= 1'b0;
      r_level      <= 2'd0;
      r_lives      <= LIVES_INIT;
    end else begin
      r_mux        <= w_mux;
      r_sel        <= w_sel;
      r_game_en    <= w_game_en;
      r_game_clear <= w_game_clear;
      r_level      <= w_level;
      r_lives      <= w_lives;
    end
  end

  assign SC_SCREEN_SEQUENCER_muxScreen_Out = r_mux;
  assign SC_SCREEN_SEQUENCER_transSel_Out  = r_sel;
  assign SC_SCREEN_SEQUENCER_gameEn_Out    = r_game_en;
  assign SC_SCREEN_SEQUENCER_gameClear_Out = r_game_clear;
  assign SC_SCREEN_SEQUENCER_level_Out     = r_level;
  assign SC_SCREEN_SEQUENCER_lives_Out     = r_lives;

endmodule

// File: tb/tb_sc_screen_sequencer.sv
// Directed scoreboard bench for sc_screen_sequencer (small timing parameters).
// Follows SC_SCREEN_SEQUENCER_CRASH_BLINK_EN for the expected CRASH behaviour.
module tb_sc_screen_sequencer;

  typedef struct packed {
    logic       mux;
    logic [1:0] sel;
    logic       en;
    logic       clr;
    logic [1:0] lvl;
    logic [1:0] lives;
  } snap_t;

  logic       clk;
  logic       rst_n;
  logic       start_n;
  logic       crash;
  logic       ld;
  logic       mux;
  logic [1:0] sel;
  logic       en;
  logic       clr;
  logic [1:0] lvl;
  logic [1:0] lives;

  snap_t exp_q[$];
  string tag_q[$];
  int    n_cmp;
  int    n_bad;
  logic [1:0] cur_sel;

  sc_screen_sequencer #(
    .PRESCALER   (2),
    .HOLD_TICKS  (3),
    .LIVES       (2),
    .LEVELS      (2),
    .BLINK_TICKS (4)
  ) dut (
    .SC_SCREEN_SEQUENCER_CLOCK_50         (clk),
    .SC_SCREEN_SEQUENCER_RESET_InLow      (rst_n),
    .SC_SCREEN_SEQUENCER_start_InLow      (start_n),
    .SC_SCREEN_SEQUENCER_crash_InHigh     (crash),
    .SC_SCREEN_SEQUENCER_levelDone_InHigh (ld),
    .SC_SCREEN_SEQUENCER_muxScreen_Out    (mux),
    .SC_SCREEN_SEQUENCER_transSel_Out     (sel),
    .SC_SCREEN_SEQUENCER_gameEn_Out       (en),
    .SC_SCREEN_SEQUENCER_gameClear_Out    (clr),
    .SC_SCREEN_SEQUENCER_level_Out        (lvl),
    .SC_SCREEN_SEQUENCER_lives_Out        (lives)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input logic m, input logic [1:0] s, input logic e,
                               input logic c, input logic [1:0] l, input logic [1:0] v);
    snap_t r;
    r.mux = m; r.sel = s; r.en = e; r.clr = c; r.lvl = l; r.lives = v;
    return r;
  endfunction

  task automatic check_one();
    snap_t e;
    snap_t o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = mk(mux, sel, en, clr, lvl, lives);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed mux=%b sel=%0d en=%b clr=%b lvl=%0d lives=%0d, expected mux=%b sel=%0d en=%b clr=%b lvl=%0d lives=%0d",
             t, o.mux, o.sel, o.en, o.clr, o.lvl, o.lives, e.mux, e.sel, e.en, e.clr, e.lvl, e.lives);
    end
  endtask

  // Queue the expectation for the inputs just driven, clock once, then compare.
  task automatic step(input string tag, input snap_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_one();
  endtask

  // Non-final crash from PLAY; levelDone is also pulsed while in CRASH.
  task automatic do_crash(input string tag, input logic with_ld, input logic [1:0] l,
                          input logic [1:0] v, inout logic [1:0] s);
    crash = 1'b1; ld = with_ld;
`ifdef SC_SCREEN_SEQUENCER_CRASH_BLINK_EN
    step({tag, "_crash_entry"}, mk(1'b1, 2'd2, 1'b0, 1'b0, l, v));
    crash = 1'b0; ld = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step({tag, "_blink"}, mk(((i / 2) % 2) == 0, 2'd2, 1'b0, 1'b0, l, v));
      ld = 1'b0;
    end
    s = 2'd2;
`else
    step({tag, "_crash_entry"}, mk(1'b0, s, 1'b0, 1'b0, l, v));
    crash = 1'b0; ld = 1'b1;
`endif
    step({tag, "_crash_return"}, mk(1'b0, s, 1'b1, 1'b1, l, v));
    ld = 1'b0;
    step({tag, "_play"}, mk(1'b0, s, 1'b1, 1'b0, l, v));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start_n = 1'b1; crash = 1'b0; ld = 1'b0;
    #1;
    step("reset", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd2));
    step("reset_hold", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd2));
    rst_n = 1'b1;
    step("idle_start", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd2));
    crash = 1'b1; ld = 1'b1;
    step("ignore_in_start", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd2));
    crash = 1'b0; ld = 1'b0;

    start_n = 1'b0;
    step("start_play", mk(1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 2'd2));
    step("start_ignored_in_play", mk(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd2));
    start_n = 1'b1;

    ld = 1'b1;
    step("level_enter", mk(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 2'd2));
    ld = 1'b0;
    for (int i = 1; i < 6; i++) step("level_hold", mk(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 2'd2));
    step("level_exit", mk(1'b0, 2'd1, 1'b1, 1'b1, 2'd1, 2'd2));
    step("level_play", mk(1'b0, 2'd1, 1'b1, 1'b0, 2'd1, 2'd2));

    ld = 1'b1;
    step("win_enter", mk(1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 2'd2));
    ld = 1'b0;
    for (int i = 1; i < 6; i++) begin
      crash = (i == 2);
      step("win_hold", mk(1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 2'd2));
    end
    crash = 1'b0;
    step("win_exit", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd2));
    step("win_idle", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 2'd2));

    start_n = 1'b0;
    step("restart", mk(1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 2'd2));
    start_n = 1'b1;
    step("restart_play", mk(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd2));
    cur_sel = 2'd0;
    do_crash("combo", 1'b1, 2'd0, 2'd1, cur_sel);

    crash = 1'b1;
    step("over_enter", mk(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0));
    crash = 1'b0;
    for (int i = 1; i < 6; i++) step("over_hold", mk(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0));
    step("over_exit", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0));

    start_n = 1'b0;
    step("third_start", mk(1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 2'd2));
    start_n = 1'b1;
    step("third_play", mk(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd2));
    cur_sel = 2'd0;
    do_crash("solo", 1'b0, 2'd0, 2'd1, cur_sel);
    ld = 1'b1;
    step("lvl2_enter", mk(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 2'd1));
    ld = 1'b0;
    step("lvl2_hold", mk(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 2'd1));
    step("lvl2_hold", mk(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 2'd1));
    rst_n = 1'b0;
    step("reset_mid_level", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd2));
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step("post_reset_idle", mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_screen_sequencer.md
SC_SCREEN_SEQUENCER -- requirements
Module: sc_screen_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- PRESCALER, 25000000, clock cycles per tick
- HOLD_TICKS, 4, ticks a LEVEL/OVER screen is held
- LIVES, 3, lives per game (1..3)
- LEVELS, 4, levels per game (1..4)
- BLINK_TICKS, 6, crash blink length in ticks (even)
REQ-002 Ports, one per line (name, direction, width, meaning):
- SC_SCREEN_SEQUENCER_CLOCK_50, in, 1, system clock
- SC_SCREEN_SEQUENCER_RESET_InLow, in, 1, reset, synchronous, active-low
- SC_SCREEN_SEQUENCER_start_InLow, in, 1, start request, one-cycle pulse
- SC_SCREEN_SEQUENCER_crash_InHigh, in, 1, collision, one-cycle pulse
- SC_SCREEN_SEQUENCER_levelDone_InHigh, in, 1, level finished, one-cycle pulse
- SC_SCREEN_SEQUENCER_muxScreen_Out, out, 1, screen mux select: 0 = game (joiner) rows, 1 = transition rows
- SC_SCREEN_SEQUENCER_transSel_Out, out, 2, transition image: 0 START, 1 LEVEL, 2 OVER, 3 WIN
- SC_SCREEN_SEQUENCER_gameEn_Out, out, 1, gameplay advance enable
- SC_SCREEN_SEQUENCER_gameClear_Out, out, 1, one-cycle field clear pulse
- SC_SCREEN_SEQUENCER_level_Out, out, 2, current level, 0-based
- SC_SCREEN_SEQUENCER_lives_Out, out, 2, remaining lives

Function
REQ-003 The FSM SHALL have the states START, PLAY, CRASH, LEVEL and OVER; all outputs SHALL be registered Moore outputs that change on the edge at which the triggering input is sampled.
REQ-004 The timer SHALL be made of a prescaler (0..PRESCALER-1) and a tick counter; both SHALL clear on every state change, so a state held for N ticks lasts exactly N*PRESCALER cycles.
REQ-005 START SHALL drive mux=1, sel=0, gameEn=0, and SHALL wait for start_InLow=0.
REQ-006 From START, a start pulse SHALL set level=0, set lives=LIVES, pulse gameClear for one cycle, and enter PLAY.
REQ-007 PLAY SHALL drive mux=0 and gameEn=1; sel SHALL hold its last value.
REQ-008 In PLAY, when crash and levelDone are high in the same cycle, crash SHALL take priority and levelDone SHALL be dropped.
REQ-009 In PLAY, a levelDone pulse with level<LEVELS-1 SHALL enter LEVEL (mux=1, sel=1, gameEn=0).
REQ-010 On LEVEL timeout after HOLD_TICKS, level SHALL increment, gameClear SHALL pulse, and the FSM SHALL return to PLAY.
REQ-011 In PLAY, a levelDone pulse with level=LEVELS-1 SHALL enter OVER with sel=3 (WIN).
REQ-012 In PLAY, a crash pulse SHALL decrement lives.
REQ-013 If lives become 0 after a crash, the FSM SHALL enter OVER with sel=2; otherwise it SHALL enter CRASH.
REQ-014 CRASH SHALL drive gameEn=0; at the end of CRASH, gameClear SHALL pulse and the FSM SHALL return to PLAY.
REQ-015 OVER SHALL drive mux=1 and gameEn=0, and after HOLD_TICKS SHALL return to START with sel=0; level and lives SHALL hold until the next start pulse.
REQ-016 Inputs outside their active state SHALL be ignored (start outside START, crash/levelDone outside PLAY).
REQ-017 The level and lives counters SHALL never wrap; the bounds LEVELS-1 and 0 SHALL be enforced by the FSM.

Reset
REQ-018 While RESET_InLow=0 at a clock edge, the block SHALL enter START with mux=1, sel=0, gameEn=0, gameClear=0, level=0, lives=LIVES, and the timer cleared.
REQ-019 A reset asserted in any state, including mid-hold or mid-blink, SHALL take effect at that edge and SHALL discard any pending transition.

Configuration
REQ-020 Macro SC_SCREEN_SEQUENCER_CRASH_BLINK_EN defined: CRASH SHALL last BLINK_TICKS ticks, and mux SHALL start at 1 and toggle on each tick (sel=2 while mux=1).
REQ-021 Macro SC_SCREEN_SEQUENCER_CRASH_BLINK_EN undefined: CRASH SHALL last exactly one cycle with mux=0, and BLINK_TICKS SHALL be unused.

Structure
REQ-022 A shared package SHALL hold the state encoding and the transSel constants (START/LEVEL/OVER/WIN); the parameter defaults SHALL stay in the module.
REQ-023 One sub-module, sc_tick_timer (prescaler plus tick counter with a synchronous clear and a done flag), SHALL be used; the FSM and counters SHALL stay in the top module.

Verification
REQ-024 With PRESCALER=2, HOLD_TICKS=3, LIVES=2, LEVELS=2 and BLINK_TICKS=4, the bench SHALL cover:
- Reset release, then start pulse -> next edge: PLAY, mux=0, gameEn=1, gameClear high for exactly one cycle, lives=2.
- levelDone in PLAY at level 0 -> LEVEL (mux=1, sel=1) for 6 cycles, then PLAY, level=1, gameClear pulse.
- levelDone at level 1 -> OVER with sel=3 for 6 cycles, then START with sel=0.
- Two crashes -> lives 2→1→0; second crash -> OVER with sel=2; with blink enabled, the first crash gives a mux pattern of 1,1,0,0,1,1,0,0 over 8 cycles.
- crash and levelDone in the same cycle -> CRASH path, level unchanged; levelDone during CRASH ignored.
- RESET_InLow=0 mid-LEVEL hold -> next edge: START, level=0, lives=2, mux=1.
